mem_bus_arbiter: RTL

- Shares one DRAM-side bus between two cache controllers: client 0 (I-cache) and client 1 (D-cache).
- Both clients use the same bus protocol as the caches. Tag bit WRITE_BIT=1 marks a read, 0 marks a write.
- Arbitration is round-robin at transaction granularity. The grant is held from the address beat until the last data or response beat.
- Sits between the two direct-mapped caches and the memory port.

---
 rtl/mem_bus_pkg.sv | 23 ++
 rtl/rr_pick2.sv | 21 ++
 rtl/mem_bus_arbiter.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the two-client memory bus arbiter.
package mem_bus_pkg;

  localparam int unsigned BUS_DATA_WIDTH = 64;
  localparam int unsigned BUS_TAG_WIDTH  = 13;
  localparam int unsigned BEATS          = 8;
  localparam int unsigned WRITE_BIT      = 12;
  localparam int unsigned BEAT_W         = $clog2(BEATS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADDR  = 2'd1,
    RDATA = 2'd2,
    WDATA = 2'd3
  } arb_state_t;

  typedef struct packed {
    logic                      reqcyc;
    logic [BUS_DATA_WIDTH-1:0] req;
    logic [BUS_TAG_WIDTH-1:0]  reqtag;
  } bus_req_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-input round-robin chooser: a tie goes to the client that did not win last.
module rr_pick2 (
  input  logic req0_i,
  input  logic req1_i,
  input  logic last_i,
  output logic gnt_valid_o,
  output logic gnt_idx_o
);

  // Pick the lone requester, or alternate on a tie.
  always_comb begin
    gnt_valid_o = req0_i | req1_i;
    gnt_idx_o   = 1'b0;
    if (req0_i && req1_i) begin
      gnt_idx_o = ~last_i;
    end else if (req1_i) begin
      gnt_idx_o = 1'b1;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the DRAM-side bus between the I-cache (client 0) and D-cache (client 1),
// holding the grant for a whole address + data transaction.
module mem_bus_arbiter
  import mem_bus_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,

  input  logic                      c0_bus_reqcyc,
  output logic                      c0_bus_reqack,
  input  logic [BUS_DATA_WIDTH-1:0] c0_bus_req,
  input  logic [BUS_TAG_WIDTH-1:0]  c0_bus_reqtag,
  output logic                      c0_bus_respcyc,
  input  logic                      c0_bus_respack,
  output logic [BUS_DATA_WIDTH-1:0] c0_bus_resp,
  output logic [BUS_TAG_WIDTH-1:0]  c0_bus_resptag,

  input  logic                      c1_bus_reqcyc,
  output logic                      c1_bus_reqack,
  input  logic [BUS_DATA_WIDTH-1:0] c1_bus_req,
  input  logic [BUS_TAG_WIDTH-1:0]  c1_bus_reqtag,
  output logic                      c1_bus_respcyc,
  input  logic                      c1_bus_respack,
  output logic [BUS_DATA_WIDTH-1:0] c1_bus_resp,
  output logic [BUS_TAG_WIDTH-1:0]  c1_bus_resptag,

  output logic                      m_bus_reqcyc,
  input  logic                      m_bus_reqack,
  output logic [BUS_DATA_WIDTH-1:0] m_bus_req,
  output logic [BUS_TAG_WIDTH-1:0]  m_bus_reqtag,
  input  logic                      m_bus_respcyc,
  output logic                      m_bus_respack,
  input  logic [BUS_DATA_WIDTH-1:0] m_bus_resp,
  input  logic [BUS_TAG_WIDTH-1:0]  m_bus_resptag,

  output logic                      proto_err
);

  arb_state_t        state_q;
  logic              grant_q;
  logic              last_q;
  logic [BEAT_W-1:0] beat_q;
  logic              is_rd_q;
  logic              proto_err_q;

  bus_req_t c0_r;
  bus_req_t c1_r;
  bus_req_t sel_r;
  logic     sel_respack;
  logic     pick_valid;
  logic     pick_idx;
  logic     last_beat;

  // Bundle each client's request path and select the granted one.
  always_comb begin
    c0_r        = '{reqcyc: c0_bus_reqcyc, req: c0_bus_req, reqtag: c0_bus_reqtag};
    c1_r        = '{reqcyc: c1_bus_reqcyc, req: c1_bus_req, reqtag: c1_bus_reqtag};
    sel_r       = grant_q ? c1_r : c0_r;
    sel_respack = grant_q ? c1_bus_respack : c0_bus_respack;
    last_beat   = (beat_q == BEAT_W'(BEATS - 1));
  end

  rr_pick2 u_pick (
    .req0_i      (c0_bus_reqcyc),
    .req1_i      (c1_bus_reqcyc),
    .last_i      (last_q),
    .gnt_valid_o (pick_valid),
    .gnt_idx_o   (pick_idx)
  );

  // Transaction FSM: arbitrate in IDLE, then track the address and data beats.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      grant_q     <= 1'b0;
      last_q      <= 1'b1;
      beat_q      <= '0;
      is_rd_q     <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      if (m_bus_respcyc && (state_q != RDATA)) begin
        proto_err_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (pick_valid) begin
            grant_q <= pick_idx;
            last_q  <= pick_idx;
            is_rd_q <= pick_idx ? c1_bus_reqtag[WRITE_BIT] : c0_bus_reqtag[WRITE_BIT];
            beat_q  <= '0;
            state_q <= ADDR;
          end
        end
        ADDR: begin
          if (sel_r.reqcyc && m_bus_reqack) begin
            state_q <= is_rd_q ? RDATA : WDATA;
          end
        end
        RDATA: begin
          if (m_bus_respcyc && sel_respack) begin
            if (last_beat) begin
              beat_q  <= '0;
              state_q <= IDLE;
            end else begin
              beat_q <= beat_q + BEAT_W'(1);
            end
          end
        end
        WDATA: begin
          if (sel_r.reqcyc && m_bus_reqack) begin
            if (last_beat) begin
              beat_q  <= '0;
              state_q <= IDLE;
            end else begin
              beat_q <= beat_q + BEAT_W'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Forward only the granted client; everything is quiet in IDLE.
  always_comb begin
    c0_bus_reqack  = 1'b0;
    c0_bus_respcyc = 1'b0;
    c0_bus_resp    = '0;
    c0_bus_resptag = '0;
    c1_bus_reqack  = 1'b0;
    c1_bus_respcyc = 1'b0;
    c1_bus_resp    = '0;
    c1_bus_resptag = '0;
    m_bus_reqcyc   = 1'b0;
    m_bus_req      = '0;
    m_bus_reqtag   = '0;
    m_bus_respack  = 1'b0;
    case (state_q)
      ADDR, WDATA: begin
        m_bus_reqcyc = sel_r.reqcyc;
        m_bus_req    = sel_r.req;
        m_bus_reqtag = sel_r.reqtag;
        if (grant_q) begin
          c1_bus_reqack = m_bus_reqack;
        end else begin
          c0_bus_reqack = m_bus_reqack;
        end
      end
      RDATA: begin
        m_bus_respack = sel_respack;
        if (grant_q) begin
          c1_bus_respcyc = m_bus_respcyc;
          c1_bus_resp    = m_bus_resp;
          c1_bus_resptag = m_bus_resptag;
        end else begin
          c0_bus_respcyc = m_bus_respcyc;
          c0_bus_resp    = m_bus_resp;
          c0_bus_resptag = m_bus_resptag;
        end
      end
      default: ;
    endcase
  end

  assign proto_err = proto_err_q;

endmodule
